// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the three-channel memory request arbiter.
package mem_arb_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned N_CH      = 3;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned COV_IDX_W = 9;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    XFER  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  localparam logic [CH_W-1:0] CH_SDRAM = 2'd0;
  localparam logic [CH_W-1:0] CH_FLASH = 2'd1;
  localparam logic [CH_W-1:0] CH_ROM   = 2'd2;

  typedef struct packed {
    state_e          state;
    logic [CH_W-1:0] grant;
    logic [1:0]      beat_cnt;
    logic [CH_W-1:0] rr_ptr;
  } cov_idx_t;

  // First valid channel after ptr, wrapping back to ptr itself last.
  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_W-1:0] ptr,
                                              input logic [N_CH-1:0] valid);
    case (ptr)
      CH_SDRAM: rr_pick = valid[CH_FLASH] ? CH_FLASH : valid[CH_ROM]   ? CH_ROM   : CH_SDRAM;
      CH_FLASH: rr_pick = valid[CH_ROM]   ? CH_ROM   : valid[CH_SDRAM] ? CH_SDRAM : CH_FLASH;
      default:  rr_pick = valid[CH_SDRAM] ? CH_SDRAM : valid[CH_FLASH] ? CH_FLASH : CH_ROM;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Request-side and sink-side signals of the memory request arbiter.
interface mem_req_arbiter_if #(parameter int unsigned DATA_W = 4);
  import mem_arb_pkg::*;

  logic [N_CH-1:0]        req_valid;
  logic [N_CH*DATA_W-1:0] req_data;
  logic [N_CH-1:0]        req_ready;
  logic                   out_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_src;
  logic [N_CH-1:0]        starve;
  logic                   abort;
  logic [COV_IDX_W-1:0]   coverage;
  logic [COV_IDX_W-1:0]   io_cov_sum;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, starve, abort, coverage, io_cov_sum
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, starve, abort, coverage, io_cov_sum
  );

endinterface

// File: rtl/mem_req_arbiter_covmap.sv
// Coverage map: counts distinct arbiter state indices seen since the last meta_reset.
module mem_arb_covmap
  import mem_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 meta_reset,
  input  cov_idx_t             cov_idx,
  output logic [COV_IDX_W-1:0] covsum
);

  logic [COV_IDX_W-1:0]      idx_q;
  logic [(1<<COV_IDX_W)-1:0] map_q;

  // No functional reset: the map must survive arbiter resets.
  always_ff @(posedge clock) begin
    idx_q <= cov_idx;
    if (meta_reset) begin
      map_q  <= '0;
      covsum <= '0;
    end else if (!map_q[idx_q]) begin
      map_q[idx_q] <= 1'b1;
      covsum       <= covsum + COV_IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin burst arbiter for SDRAM/FLASH/ROM onto one sink, with starvation flags.
// Define ARB_COVERAGE_EN to build the state-coverage map behind coverage/io_cov_sum.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned BURST      = 4,
  parameter int unsigned STARVE_MAX = 15
) (
  input logic              clock,
  input logic              reset,
  input logic              meta_reset,
  mem_req_arbiter_if.slave bus
);

  localparam int unsigned BEAT_W = 2;
  localparam int unsigned WAIT_W = 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STARVE_MAX);

  state_e                      state_q, state_d;
  logic [CH_W-1:0]             grant_q, grant_d;
  logic [CH_W-1:0]             rr_q, rr_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [N_CH-1:0][WAIT_W-1:0] wait_q, wait_d;

  logic [N_CH-1:0][DATA_W-1:0] ch_data;
  logic                        any_req;
  logic                        gnt_valid;

  assign ch_data   = bus.req_data;
  assign any_req   = |bus.req_valid;
  assign gnt_valid = bus.req_valid[grant_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= CH_SDRAM;
      rr_q    <= CH_ROM;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    beat_d        = beat_q;
    wait_d        = wait_q;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_src   = '0;
    bus.req_ready = '0;
    bus.abort     = 1'b0;

    case (state_q)
      IDLE: if (any_req) state_d = ARB;
      ARB: begin
        if (any_req) begin
          grant_d = rr_pick(rr_q, bus.req_valid);
          beat_d  = '0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        bus.out_valid          = gnt_valid;
        bus.out_data           = ch_data[grant_q];
        bus.out_src            = grant_q;
        bus.req_ready[grant_q] = bus.out_ready;
        if (!gnt_valid) begin
          state_d = (beat_q != '0) ? ABORT : IDLE;
        end else if (bus.out_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        rr_d    = grant_q;
        state_d = any_req ? ARB : IDLE;
      end
      ABORT: begin
        bus.abort = 1'b1;
        rr_d      = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Waiting = requesting but not the channel currently streaming.
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!bus.req_valid[i] || (state_q == ARB && state_d == XFER && grant_d == CH_W'(i))) begin
        wait_d[i] = '0;
      end else if (!(state_q == XFER && grant_q == CH_W'(i)) && wait_q[i] != WAIT_SAT) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) bus.starve[i] = (wait_q[i] == WAIT_SAT);
  end

`ifdef ARB_COVERAGE_EN
  cov_idx_t             cov_idx;
  logic [COV_IDX_W-1:0] covsum;

  always_comb begin
    cov_idx.state    = state_q;
    cov_idx.grant    = grant_q;
    cov_idx.beat_cnt = beat_q;
    cov_idx.rr_ptr   = rr_q;
  end

  mem_arb_covmap u_covmap (
    .clock      (clock),
    .meta_reset (meta_reset),
    .cov_idx    (cov_idx),
    .covsum     (covsum)
  );

  assign bus.coverage   = covsum;
  assign bus.io_cov_sum = covsum;
`else
  logic unused_meta_reset;
  assign unused_meta_reset = meta_reset;
  assign bus.coverage      = '0;
  assign bus.io_cov_sum    = '0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: vector table, directed corner cases, random traffic vs model.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int DW    = 4;
  localparam int BURST = 4;
  localparam int SMAX  = 15;
  localparam int P_IDLE = 0, P_ARB = 1, P_XFER = 2, P_DONE = 3, P_ABORT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic meta_reset = 1'b0;

  mem_req_arbiter_if #(.DATA_W(DW)) bus();

  mem_req_arbiter #(.DATA_W(DW), .BURST(BURST), .STARVE_MAX(SMAX)) dut (
    .clock      (clock),
    .reset      (reset),
    .meta_reset (meta_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // Reference model, in the arbiter's observable terms.
  int m_mode, m_grant, m_last, m_beats;
  int m_wait[3];
`ifdef ARB_COVERAGE_EN
  bit seen[512];
  int m_cov, m_cov_reg;
`endif

  typedef struct {
    logic [2:0] rv;
    logic       ordy;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] es;
    logic [2:0] err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic mreset();
    m_mode = P_IDLE; m_grant = 0; m_last = 2; m_beats = 0;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  function automatic int pick(input int last, input logic [2:0] rv);
    for (int off = 1; off <= 3; off++)
      if (rv[(last + off) % 3]) return (last + off) % 3;
    return last;
  endfunction

  function automatic int cov_exp();
`ifdef ARB_COVERAGE_EN
    return m_cov;
`else
    return 0;
`endif
  endfunction

  task automatic advance(input logic [2:0] rv, input logic ordy);
    int nm;
    bit enter;
    nm = m_mode;
    enter = 1'b0;
    case (m_mode)
      P_IDLE: if (rv != 0) nm = P_ARB;
      P_ARB: begin
        if (rv != 0) begin
          m_grant = pick(m_last, rv); m_beats = 0; nm = P_XFER; enter = 1'b1;
        end else nm = P_IDLE;
      end
      P_XFER: begin
        if (!rv[m_grant]) nm = (m_beats != 0) ? P_ABORT : P_IDLE;
        else if (ordy) begin
          if (m_beats == BURST - 1) nm = P_DONE;
          m_beats = (m_beats + 1) % 4;
        end
      end
      P_DONE:  begin m_last = m_grant; nm = (rv != 0) ? P_ARB : P_IDLE; end
      default: begin m_last = m_grant; nm = P_IDLE; end
    endcase
    for (int i = 0; i < 3; i++) begin
      if (!rv[i] || (enter && m_grant == i)) m_wait[i] = 0;
      else if (!(m_mode == P_XFER && m_grant == i) && m_wait[i] < SMAX) m_wait[i]++;
    end
    m_mode = nm;
  endtask

  task automatic drive(input logic [2:0] rv, input logic [11:0] data, input logic ordy);
    bus.req_valid = rv;
    bus.req_data  = data;
    bus.out_ready = ordy;
  endtask

  // Compare every output against the model, then step model and clock together.
  task automatic tick(input string name);
    logic [31:0] e;
    logic [2:0]  rv, rr, stv;
    logic [3:0]  dat;
    int          idx_now;
    #1;
    if (!reset) mreset();
    rv  = bus.req_valid;
    dat = bus.req_data[m_grant*DW +: DW];
    rr  = (m_mode == P_XFER && bus.out_ready) ? 3'(1 << m_grant) : 3'b000;
    for (int i = 0; i < 3; i++) stv[i] = (m_wait[i] == SMAX);
    e = {(m_mode == P_XFER) && rv[m_grant], (m_mode == P_XFER) ? dat : 4'h0,
         (m_mode == P_XFER) ? 2'(m_grant) : 2'b00, rr, stv, m_mode == P_ABORT,
         9'(cov_exp()), 9'(cov_exp())};
    check(name, {bus.out_valid, bus.out_data, bus.out_src, bus.req_ready, bus.starve,
                 bus.abort, bus.coverage, bus.io_cov_sum}, e);
    idx_now = (m_mode << 6) | (m_grant << 4) | (m_beats << 2) | m_last;
    if (reset) advance(rv, bus.out_ready);
`ifdef ARB_COVERAGE_EN
    if (meta_reset) begin
      foreach (seen[j]) seen[j] = 1'b0;
      m_cov = 0;
    end else if (!seen[m_cov_reg]) begin
      seen[m_cov_reg] = 1'b1;
      m_cov++;
    end
    m_cov_reg = idx_now;
`else
    idx_now = 0;
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick("reset_pulse");
    reset = 1'b1;
  endtask

  initial begin
    vec_t        tbl[11];
    logic [1:0]  srcs[$];
    logic [2:0]  rv;
    logic        rst_now;

    drive(3'b000, 12'h000, 1'b0);
    meta_reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    meta_reset = 1'b0;
    mreset();
`ifdef ARB_COVERAGE_EN
    foreach (seen[j]) seen[j] = 1'b0;
    m_cov = 0;
    m_cov_reg = (P_IDLE << 6) | (0 << 4) | (0 << 2) | 2;
`endif
    tick("reset_state");
    reset = 1'b1;

    // All three channels requesting: bursts rotate SDRAM, FLASH, ROM, SDRAM.
    drive(3'b111, 12'h321, 1'b1);
    for (int c = 0; c < 26; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) srcs.push_back(bus.out_src);
      tick("rr_all");
    end
    check("rr_nbeats", 32'(srcs.size() >= 16), 32'd1);
    for (int k = 0; k < 16 && k < srcs.size(); k++)
      check("rr_order", 32'(srcs[k]), 32'((k / 4) % 3));

`ifdef ARB_COVERAGE_EN
    check("cov_nonzero", 32'(bus.coverage != 0), 32'd1);
    meta_reset = 1'b1;
    tick("meta");
    meta_reset = 1'b0;
    check("cov_cleared", 32'(bus.coverage), 32'd0);
    tick("cov_recount");
    check("cov_one", 32'(bus.coverage), 32'd1);
    repeat (6) tick("cov_rerun");
`endif

    // ROM alone, vector table with hand-derived outputs.
    do_reset();
    tbl[0]  = '{3'b100, 1'b1, 1'b0, 4'h0, 2'd0, 3'b000};
    tbl[1]  = '{3'b100, 1'b1, 1'b0, 4'h0, 2'd0, 3'b000};
    tbl[2]  = '{3'b100, 1'b1, 1'b1, 4'hA, 2'd2, 3'b100};
    tbl[3]  = '{3'b100, 1'b1, 1'b1, 4'hA, 2'd2, 3'b100};
    tbl[4]  = '{3'b100, 1'b1, 1'b1, 4'hA, 2'd2, 3'b100};
    tbl[5]  = '{3'b100, 1'b1, 1'b1, 4'hA, 2'd2, 3'b100};
    tbl[6]  = '{3'b100, 1'b1, 1'b0, 4'h0, 2'd0, 3'b000};
    tbl[7]  = '{3'b100, 1'b1, 1'b0, 4'h0, 2'd0, 3'b000};
    tbl[8]  = '{3'b100, 1'b1, 1'b1, 4'hA, 2'd2, 3'b100};
    tbl[9]  = '{3'b100, 1'b0, 1'b1, 4'hA, 2'd2, 3'b000};
    tbl[10] = '{3'b100, 1'b1, 1'b1, 4'hA, 2'd2, 3'b100};
    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].rv, 12'hA00, tbl[r].ordy);
      #1;
      check("rom_table", {22'd0, bus.out_valid, bus.out_data, bus.out_src, bus.req_ready},
            {22'd0, tbl[r].ev, tbl[r].ed, tbl[r].es, tbl[r].err});
      tick("rom_model");
    end

    // FLASH drops its request after two beats.
    do_reset();
    drive(3'b010, 12'h050, 1'b1);
    repeat (4) tick("abort_setup");
    drive(3'b001, 12'h050, 1'b1);
    tick("abort_drop");
    drive(3'b011, 12'h050, 1'b1);
    #1;
    check("abort_pulse", 32'(bus.abort), 32'd1);
    tick("abort_state");
    check("abort_gone", 32'(bus.abort), 32'd0);
    tick("abort_idle");
    tick("abort_arb");
    check("abort_regrant", {30'd0, bus.out_src}, 32'd0);
    check("abort_regrant_v", 32'(bus.out_valid), 32'd1);
    tick("abort_xfer");

    // SDRAM stalled by the sink while FLASH waits.
    do_reset();
    drive(3'b011, 12'h021, 1'b0);
    repeat (22) tick("stall");
    check("stall_starve", 32'(bus.starve), 32'b010);
    check("stall_valid", 32'(bus.out_valid), 32'd1);

    // Async reset in the middle of a burst.
    bus.out_ready = 1'b1;
    repeat (2) tick("pre_reset");
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_cov", 32'(bus.coverage), 32'(cov_exp()));
    tick("rst_hold");
    reset = 1'b1;
    repeat (4) tick("post_reset");

    // Random traffic against the model.
    rv = 3'b000;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(7) == 0) rv[i] = ~rv[i];
      rst_now = ($urandom_range(199) == 0);
      drive(rv, 12'($urandom), $urandom_range(3) != 0);
      meta_reset = ($urandom_range(49) == 0);
      reset = !rst_now;
      tick("random");
    end
    meta_reset = 1'b0;
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
